// File: rtl/reg_serializer.sv
// Parallel-to-serial shifter with a valid/ready handshake on both sides.
// Bit order is LSB first unless REG_SERIALIZER_MSB_FIRST_EN is defined.
module reg_serializer #(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] load_data,
   input  logic         load_valid,
   output logic         load_ready,
   output logic         ser_out,
   output logic         ser_valid,
   output logic         ser_last,
   input  logic         ser_ready
);

   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t        state_q, state_d;
   logic [N-1:0]  sh_q, sh_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          last_q, last_d;
   logic          valid_q, valid_d;
   logic          ready_q, ready_d;

   always_comb begin
      state_d = state_q;
      sh_d    = sh_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (load_valid) begin
               state_d = SHIFT;
               sh_d    = load_data;
               cnt_d   = '0;
            end else begin
               state_d = IDLE;
            end
         end
         SHIFT: begin
            if (ser_ready) begin
               // Clearing on exit keeps ser_out at 0 throughout IDLE.
               if (cnt_q == LAST_IDX) begin
                  state_d = IDLE;
                  sh_d    = '0;
                  cnt_d   = '0;
               end else begin
`ifdef REG_SERIALIZER_MSB_FIRST_EN
                  sh_d  = sh_q << 1;
`else
                  sh_d  = sh_q >> 1;
`endif
                  cnt_d = cnt_q + CW'(1);
               end
            end else begin
               state_d = SHIFT;
            end
         end
         default: begin
            state_d = IDLE;
            sh_d    = '0;
            cnt_d   = '0;
         end
      endcase
      valid_d = (state_d == SHIFT);
      ready_d = (state_d == IDLE);
      last_d  = (state_d == SHIFT) && (cnt_d == LAST_IDX);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         sh_q    <= '0;
         cnt_q   <= '0;
         last_q  <= 1'b0;
         valid_q <= 1'b0;
         ready_q <= 1'b1;
      end else begin
         state_q <= state_d;
         sh_q    <= sh_d;
         cnt_q   <= cnt_d;
         last_q  <= last_d;
         valid_q <= valid_d;
         ready_q <= ready_d;
      end
   end

`ifdef REG_SERIALIZER_MSB_FIRST_EN
   assign ser_out = sh_q[N-1];
`else
   assign ser_out = sh_q[0];
`endif
   assign ser_valid  = valid_q;
   assign ser_last   = last_q;
   assign load_ready = ready_q;

endmodule

// File: doc/reg_serializer.md
REG_SERIALIZER -- requirements
Module: reg_serializer

Interface
REQ-001: The block SHALL have a parameter N, default 32, giving the width of the parallel word accepted and shifted out.
REQ-002: Port clk, input, 1 bit, SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003: Port rst, input, 1 bit, SHALL be the synchronous, active-high reset.
REQ-004: Port load_data, input, N bits, SHALL carry the parallel word, sampled only on load handshake.
REQ-005: Port load_valid, input, 1 bit, SHALL indicate that load_data holds a word to send.
REQ-006: Port load_ready, output, 1 bit, SHALL indicate that the block can accept a word.
REQ-007: Port ser_out, output, 1 bit, SHALL carry the current serial bit.
REQ-008: Port ser_valid, output, 1 bit, SHALL indicate that ser_out holds a valid bit.
REQ-009: Port ser_last, output, 1 bit, SHALL mark the final bit of the current word.
REQ-010: Port ser_ready, input, 1 bit, SHALL indicate that the consumer takes ser_out this cycle.

Function
REQ-011: The block SHALL implement two states: IDLE (load_ready=1, ser_valid=0) and SHIFT (load_ready=0, ser_valid=1).
REQ-012: A load SHALL occur on a rising edge with load_valid=1 and load_ready=1; the word is captured into an N-bit shift register, the bit counter is cleared, and the state moves to SHIFT.
REQ-013: ser_valid SHALL assert exactly one cycle after the accepting edge, i.e. latency 1.
REQ-014: In SHIFT, a bit SHALL be consumed on each edge with ser_valid=1 and ser_ready=1; the shift register then advances one position and the counter increments.
REQ-015: With ser_ready=0 in SHIFT, ser_out, ser_last, the counter and the shift register SHALL hold unchanged.
REQ-016: By default the bit order SHALL be LSB first, so bit k of the word is presented as the k-th serial bit, counting from 0.
REQ-017: The counter SHALL be max(1, clog2(N)) bits wide, and ser_last SHALL be 1 exactly when the counter equals N-1 in SHIFT, and 0 otherwise.
REQ-018: Consumption of the bit with ser_last=1 SHALL return the state to IDLE, with load_ready=1 on the following cycle.
REQ-019: Each word SHALL therefore occupy at least N+1 cycles: one IDLE cycle plus N SHIFT cycles.
REQ-020: load_valid asserted during SHIFT, including the cycle in which the last bit is consumed, SHALL be ignored, and that data SHALL NOT be captured.
REQ-021: In IDLE, ser_out and ser_last SHALL be 0.
REQ-022: With N=1, the single bit SHALL be presented with ser_last=1.

Reset
REQ-023: rst=1 SHALL, on the next rising edge and regardless of state, force IDLE, clear the shift register and the counter, and drive ser_valid=0, ser_last=0, ser_out=0 and load_ready=1.
REQ-024: Reset mid-word SHALL discard the remaining bits with no partial continuation after rst deasserts.
REQ-025: rst SHALL take priority over a simultaneous load or bit handshake.

Configuration
REQ-026: When macro REG_SERIALIZER_MSB_FIRST_EN is defined, the bit order SHALL be MSB first, with bit N-1 presented first; counter, ser_last and handshake behaviour SHALL be unchanged.
REQ-027: When REG_SERIALIZER_MSB_FIRST_EN is undefined, the LSB-first order of REQ-016 SHALL apply.

Verification
REQ-028: Reset: hold rst=1 for 2 cycles -> load_ready=1, ser_valid=0, ser_out=0, ser_last=0.
REQ-029: Stream: load 0x8000_0001 with ser_ready=1 (LSB first) -> ser_out is 1, then 30 zeros, then 1; ser_last=1 only on bit 31; load_ready=1 on the next cycle; 33 cycles from load to next load_ready.
REQ-030: Backpressure: load 0xA5A5_A5A5, hold ser_ready=0 for 3 cycles at bit 5 -> ser_out and ser_last are stable, and the reassembled word equals 0xA5A5_A5A5.
REQ-031: Ignore: hold load_valid=1 with 0xFFFF_FFFF during the shift of 0x0000_0000 -> 32 zeros are output; 0xFFFF_FFFF is accepted only in the following IDLE cycle.
REQ-032: Reset mid-word: pulse rst after 10 bits of 0x1234_5678 -> IDLE on the next cycle; a new load of 0x0000_00FF then shifts 8 ones followed by 24 zeros.
REQ-033: MSB-first, with REG_SERIALIZER_MSB_FIRST_EN defined: load 0x0000_0003 -> 30 zeros, then 1, 1, with ser_last on the final 1.
